// File: rtl/alu_pkg.sv
// Shared op-code and FSM encodings for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_MULT = 3'd3;
  localparam logic [2:0] ALU_DIV  = 3'd4;
  localparam logic [2:0] ALU_SLTU = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLT  = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Shared one-bit-per-cycle engine: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               last
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // mode 0: {acc, sr} is the partial product; mode 1: acc is the remainder, sr the quotient.
  always_comb begin
    acc_d   = acc_q;
    sr_d    = sr_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    add_sum = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_q, sr_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    if (load) begin
      acc_d = '0;
      sr_d  = mag_a;
      opb_d = mag_b;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CntW'(1);
      if (!mode) begin
        acc_d = add_sum[WIDTH:1];
        sr_d  = {add_sum[0], sr_q[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      sr_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sr_q  <= sr_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

  assign product   = {acc_q, sr_q};
  assign quotient  = sr_q;
  assign remainder = acc_q;
  assign last      = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops plus iterative signed MULT and DIV.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             dbz
);

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] y_q, y_d, hi_q, hi_d;
  logic             zero_q, zero_d, dbz_q, dbz_d, done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] single_res;
  logic             iter_load, iter_step, iter_last;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot, rem, quot_fix, rem_fix;

  assign a_neg = A[WIDTH-1];
  assign b_neg = B[WIDTH-1];
  assign mag_a = a_neg ? -A : A;
  assign mag_b = b_neg ? -B : B;

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (iter_load),
    .step     (iter_step),
    .mode     (state_q == StDiv),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .product  (prod),
    .quotient (quot),
    .remainder(rem),
    .last     (iter_last)
  );

  always_comb begin
    single_res = '0;
    unique case (control)
      ALU_AND:  single_res = A & B;
      ALU_OR:   single_res = A | B;
      ALU_ADD:  single_res = A + B;
      ALU_SUB:  single_res = A - B;
      ALU_SLT:  single_res[0] = $signed(A) < $signed(B);
      ALU_SLTU: single_res[0] = A < B;
      default:  single_res = '0;
    endcase
  end

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -quot : quot;
    rem_fix  = rem_neg_q ? -rem : rem;
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    y_d       = y_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    iter_load = 1'b0;
    iter_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (control == ALU_MULT) begin
            iter_load = 1'b1;
            is_div_d  = 1'b0;
            neg_d     = a_neg ^ b_neg;
            state_d   = StMul;
          end else if (control == ALU_DIV && B == '0) begin
            y_d    = '1;
            hi_d   = A;
            zero_d = 1'b0;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else if (control == ALU_DIV) begin
            iter_load = 1'b1;
            is_div_d  = 1'b1;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            state_d   = StDiv;
          end else begin
            y_d    = single_res;
            hi_d   = '0;
            zero_d = ~|single_res;
            dbz_d  = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      StMul, StDiv: begin
        iter_step = 1'b1;
        if (iter_last) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          y_d  = quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, y_d} = prod_fix;
        end
        zero_d  = ~|y_d;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      y_q       <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      y_q       <= y_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign y    = y_q;
  assign hi   = hi_q;
  assign zero = zero_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;

  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_MULT = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_SLTU = 3'd5, OP_SUB = 3'd6, OP_SLT = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  control = 3'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done, zero, dbz;
  logic [31:0] y, hi;

  int n_checks = 0;
  int n_fail = 0;

  alu_mc #(
    .WIDTH(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .control(control),
    .A      (op_a),
    .B      (op_b),
    .busy   (busy),
    .done   (done),
    .y      (y),
    .hi     (hi),
    .zero   (zero),
    .dbz    (dbz)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    control = op;
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles from the accepting edge until done; busy must hold for the first 32 cycles.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = (busy === 1'b1);
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat <= 31 && busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, y, hi, zero, dbz} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b y=%h hi=%h zero=%b dbz=%b, want all 0",
               busy, done, y, hi, zero, dbz);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single;
    logic [2:0]  ops[8]  = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_SLT, OP_SLTU};
    logic [31:0] av[8]   = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0,
                             32'hF0F0, 32'd1, 32'd1};
    logic [31:0] bv[8]   = '{32'd1, 32'd5, 32'd1, 32'd1, 32'hFF00, 32'hFF00, 32'hFFFFFFFF,
                             32'hFFFFFFFF};
    logic [31:0] ev[8]   = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'hF000, 32'hFFF0, 32'd0,
                             32'd1};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], av[i], bv[i]);
      n_checks++;
      if ({done, y, hi, zero, dbz} !== {1'b1, ev[i], 32'd0, ev[i] == 0, 1'b0}) begin
        n_fail++;
        $display("FAIL single_op[%0d]: got done=%b y=%h hi=%h zero=%b dbz=%b, want y=%h",
                 i, done, y, hi, zero, dbz, ev[i]);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || y !== ev[i]) begin
        n_fail++;
        $display("FAIL single_pulse[%0d]: got done=%b y=%h, want done=0 y=%h", i, done, y, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] av[4] = '{32'd1, 32'd10, 32'd3, 32'd100};
    logic [31:0] bv[4] = '{32'd2, 32'd4, 32'd5, 32'd1};
    logic [31:0] ev[4] = '{32'd3, 32'd6, 32'd8, 32'd99};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      control = (i % 2 == 1 || i == 3) ? OP_SUB : OP_ADD;
      op_a = av[i];
      op_b = bv[i];
      start = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b1 || y !== ev[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got done=%b y=%h, want done=1 y=%h", i, done, y, ev[i]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_mult;
    logic [31:0] av[3] = '{32'hFFFFFFFD, 32'h80000000, 32'h00010000};
    logic [31:0] bv[3] = '{32'd7, 32'h80000000, 32'h00010000};
    logic [63:0] ev[3] = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'h00000001_00000000};
    int lat;
    bit bok;
    for (int i = 0; i < 3; i++) begin
      issue(OP_MULT, av[i], bv[i]);
      wait_done(lat, bok);
      n_checks++;
      if (lat !== 33 || !bok || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mult_timing[%0d]: got latency=%0d busy_ok=%b busy=%b, want 33/1/0",
                 i, lat, bok, busy);
      end
      n_checks++;
      if ({hi, y} !== ev[i] || zero !== (ev[i][31:0] == 0) || dbz !== 1'b0) begin
        n_fail++;
        $display("FAIL mult_result[%0d]: got hi:y=%h zero=%b dbz=%b, want %h", i, {hi, y},
                 zero, dbz, ev[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [31:0] av[4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100};
    logic [31:0] bv[4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7};
    logic [31:0] eq[4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14};
    logic [31:0] er[4] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd2};
    int lat;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      issue(OP_DIV, av[i], bv[i]);
      wait_done(lat, bok);
      n_checks++;
      if (lat !== 33 || !bok) begin
        n_fail++;
        $display("FAIL div_timing[%0d]: got latency=%0d busy_ok=%b, want 33/1", i, lat, bok);
      end
      n_checks++;
      if (y !== eq[i] || hi !== er[i] || dbz !== 1'b0 || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL div_result[%0d]: got y=%h hi=%h dbz=%b zero=%b, want y=%h hi=%h",
                 i, y, hi, dbz, zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_dbz;
    issue(OP_DIV, 32'd9, 32'd0);
    n_checks++;
    if ({done, busy, y, hi, dbz, zero} !== {1'b1, 1'b0, 32'hFFFFFFFF, 32'd9, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL div_by_zero: got done=%b busy=%b y=%h hi=%h dbz=%b zero=%b, want 1 0 ffffffff 9 1 0",
               done, busy, y, hi, dbz, zero);
    end
    issue(OP_ADD, 32'd1, 32'd1);
    n_checks++;
    if (dbz !== 1'b0 || y !== 32'd2 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL dbz_clear: got dbz=%b y=%h hi=%h, want 0 2 0", dbz, y, hi);
    end
  endtask

  task automatic test_handshake;
    int lat = 0;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 5 || lat == 20) begin
        start = 1'b1;
        control = OP_ADD;
        op_a = lat;
        op_b = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    n_checks++;
    if (lat !== 33 || {hi, y} !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_fail++;
      $display("FAIL busy_ignore: got latency=%0d hi:y=%h, want 33 ffffffffffffffeb", lat, {hi, y});
    end
    // Still in the done cycle: busy is already low, so this start must be taken.
    start = 1'b1;
    control = OP_ADD;
    op_a = 32'd2;
    op_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || y !== 32'd5 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL start_in_done: got done=%b y=%h hi=%h, want 1 5 0", done, y, hi);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    bit bok;
    bit seen = 1'b0;
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, y, hi, zero, dbz} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b y=%h hi=%h zero=%b dbz=%b, want all 0",
               busy, done, y, hi, zero, dbz);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got done/busy activity=%b, want 0", seen);
    end
    issue(OP_ADD, 32'd2, 32'd2);
    n_checks++;
    if (done !== 1'b1 || y !== 32'd4) begin
      n_fail++;
      $display("FAIL fresh_add: got done=%b y=%h, want 1 4", done, y);
    end
    issue(OP_DIV, 32'd100, 32'd7);
    wait_done(lat, bok);
    n_checks++;
    if (lat !== 33 || y !== 32'd14 || hi !== 32'd2) begin
      n_fail++;
      $display("FAIL fresh_div: got latency=%0d y=%h hi=%h, want 33 e 2", lat, y, hi);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_mult;
    test_div;
    test_dbz;
    test_handshake;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle successor to the datapath ALU. It keeps the 3-bit AND/OR/ADD/SUB/SLT encoding and adds signed multiply, signed divide and unsigned set-less-than. Operands are accepted through a start/busy/done handshake and results are registered. It sits in the EX stage of the multi-cycle MIPS datapath and drives the result register and the HI/LO pair.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥4, even).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- control  input  3  op: 0 AND, 1 OR, 2 ADD, 3 MULT, 4 DIV, 5 SLTU, 6 SUB, 7 SLT.
- A, B  input  WIDTH  signed operands (two's complement; SLTU treats them unsigned).
- busy  output  1  iterative op in progress; start ignored.
- done  output  1  one-cycle pulse: y/hi/zero/dbz updated this cycle.
- y  output  WIDTH  result / LO / quotient.
- hi  output  WIDTH  MULT high half, DIV remainder, else 0.
- zero  output  1  y == 0.
- dbz  output  1  last DIV had B == 0.

## Operation
- FSM states are IDLE, MUL, DIV and FIX. Only IDLE accepts start.
- Single-cycle ops (0,1,2,5,6,7) are handled at the accepting edge:
  - y is registered with wrap-around.
  - ADD/SUB ignore overflow.
  - SLT compares signed; SLTU compares unsigned.
  - hi=0 and dbz=0.
  - done=1 for the next cycle.
  - The FSM stays in IDLE.
- MULT (3):
  - The operand magnitudes are latched along with the result sign (A[MSB]^B[MSB]).
  - Shift-add runs one bit per cycle for WIDTH cycles in MUL.
  - FIX negates the 2·WIDTH product if the sign is set, then writes {hi,y}.
- DIV (4):
  - The magnitudes are latched.
  - Restoring division runs one bit per cycle for WIDTH cycles in DIV.
  - FIX applies the signs:
    - The quotient truncates toward zero.
    - The remainder takes the sign of A.
- DIV with B==0 does not enter DIV. At the accepting edge: y = all ones, hi = A, dbz=1, and done=1 next cycle.
- DIV of MIN/−1 gives y=MIN and hi=0. This falls out of the magnitude path and must not trap.
- An undefined code cannot occur, because all 8 codes are defined.
- zero is registered together with y as ~|y_next.
- Outputs hold their value between done pulses.

## Timing
- All outputs reset to 0: y, hi, zero, dbz, busy, done. State resets to IDLE and the counter to 0.
  - Note that zero resets to 0 even though y=0. This is deliberate: there is no valid result yet.
- Single-cycle op accepted at edge k: done=1 and results valid in the cycle after k, i.e. latency 1.
- MULT/DIV accepted at edge k:
  - busy=1 from after edge k through edge k+WIDTH.
  - FIX runs after edge k+WIDTH.
  - At edge k+WIDTH+1 results are written, done=1, busy=0 and the state returns to IDLE.
  - Latency is WIDTH+1 cycles.
- Back-to-back issue:
  - start is allowed in the same cycle that done=1, because busy is already 0.
  - A single-cycle op can issue every cycle.
- start while busy=1 is ignored. It is not queued, and operands may change freely.
- A, B and control are sampled only at the accepting edge. Iterations use the latched copies.
- If rst is asserted mid-operation, the operation aborts immediately and all outputs return to reset values. No done pulse follows the release of reset.
- The iteration counter is $clog2(WIDTH)+1 bits wide and does not wrap within an operation.

## Structure
- Package alu_pkg holds:
  - the op-code localparams ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_MULT=3, ALU_DIV=4, ALU_SLTU=5, ALU_SUB=6, ALU_SLT=7;
  - the FSM state encoding.
- Sub-module muldiv_iter (parameter WIDTH) contains the shared shift register, accumulator and counter for both the MULT and DIV iterations.
  - Interface: load, mode, magnitudes in; product/quotient/remainder out; last-cycle flag.
- The top module holds the FSM, the single-cycle ops, sign handling and the output registers.

## Test plan
All cases use WIDTH=32.
- Single-cycle sweep:
  - ADD 0x7FFFFFFF+1 → y=0x80000000, zero=0.
  - SUB 5−5 → y=0, zero=1.
  - SLT −1<1 → y=1.
  - SLTU 0xFFFFFFFF<1 → y=0.
  - Each gives done exactly 1 cycle after start.
- MULT:
  - −3×7 → {hi,y}=0xFFFFFFFF_FFFFFFEB.
  - 0x80000000×0x80000000 → hi=0x40000000, y=0.
  - For both: busy for 32 cycles and done exactly 33 cycles after the accepting edge.
- DIV:
  - −7/2 → y=−3, hi=−1.
  - 7/−2 → y=−3, hi=1.
  - 0x80000000/−1 → y=0x80000000, hi=0.
  - Each has latency 33.
- Divide by zero:
  - 9/0 → y=0xFFFFFFFF, hi=9, dbz=1, latency 1.
  - A following ADD clears dbz.
- Handshake: pulse start again at cycles 5 and 20 of a MULT with new operands. Required: both are ignored and the result matches the original operands. A start in the done cycle is accepted.
- Reset: assert rst at cycle 10 of a DIV. Required: busy/done/y/hi/zero/dbz=0 immediately, no done after release, and a fresh op then completes normally.
